decode_ctrl: RTL

- Decode-stage controller between instruction fetch and execute.
- Accepts a fetched instruction and PC over a valid/ready handshake and classifies the opcode.
- Produces the 3-bit ImmSel code consumed by the immediate generator, plus register indices, operand-use flags and an illegal flag.
- Registers everything through a 2-entry skid buffer, so back-pressure from execute never loses an instruction and never creates a combinational ready path.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/decode_lut.sv | 69 ++++++
 rtl/decode_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode definitions shared by the decode stage: opcodes, immediate
// format codes and the per-instruction decode record.
package rv32i_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned IMM_W = 3;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [IMM_W-1:0] {
        IMM_I  = 3'b000,
        IMM_IU = 3'b001,
        IMM_S  = 3'b010,
        IMM_B  = 3'b011,
        IMM_U  = 3'b100,
        IMM_J  = 3'b101
    } imm_sel_e;

    typedef struct packed {
        imm_sel_e         imm_sel;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_we;
        logic             illegal;
    } decode_t;

endpackage

// File: rtl/decode_lut.sv
// Combinational RV32I opcode classifier: immediate format, register indices,
// operand-use / writeback flags and illegal detection.
module decode_lut
    import rv32i_pkg::*;
(
    input  logic [24:0] i_inst,
    output decode_t     o_dec_c
);

    logic [OPC_W-1:0] w_opc;
    logic [2:0]       w_funct3;
    logic             w_rd_nz;

    assign w_opc    = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_rd_nz  = |i_inst[11:7];

    always_comb begin
        o_dec_c         = '0;
        o_dec_c.imm_sel = IMM_I;
        o_dec_c.rd      = i_inst[11:7];
        o_dec_c.rs1     = i_inst[19:15];
        o_dec_c.rs2     = i_inst[24:20];
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                o_dec_c.imm_sel = IMM_U;
                o_dec_c.rd_we   = w_rd_nz;
            end
            OPC_JAL: begin
                o_dec_c.imm_sel = IMM_J;
                o_dec_c.rd_we   = w_rd_nz;
            end
            OPC_JALR, OPC_LOAD: begin
                o_dec_c.rs1_used = 1'b1;
                o_dec_c.rd_we    = w_rd_nz;
            end
            OPC_OPIMM: begin
                // shift-immediates carry shamt/funct7 instead of a 12-bit immediate
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    o_dec_c.imm_sel = IMM_IU;
                end
                o_dec_c.rs1_used = 1'b1;
                o_dec_c.rd_we    = w_rd_nz;
            end
            OPC_STORE: begin
                o_dec_c.imm_sel  = IMM_S;
                o_dec_c.rs1_used = 1'b1;
                o_dec_c.rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                o_dec_c.imm_sel  = IMM_B;
                o_dec_c.rs1_used = 1'b1;
                o_dec_c.rs2_used = 1'b1;
            end
            OPC_OP: begin
                o_dec_c.rs1_used = 1'b1;
                o_dec_c.rs2_used = 1'b1;
                o_dec_c.rd_we    = w_rd_nz;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                o_dec_c.imm_sel = IMM_I;
            end
            default: begin
                o_dec_c.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: classifies fetched instructions and registers them
// through a two-entry skid buffer toward execute.
module decode_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          FLUSH_PC_KEEP = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [XLEN-1:0]   i_inst,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_inst,
    output logic [XLEN-1:0]   o_pc,
    output logic [IMM_W-1:0]  o_ImmSel,
    output logic [REG_W-1:0]  o_rd,
    output logic [REG_W-1:0]  o_rs1,
    output logic [REG_W-1:0]  o_rs2,
    output logic              o_rs1_used,
    output logic              o_rs2_used,
    output logic              o_rd_we,
    output logic              o_illegal
);

    decode_t         w_in_dec;

    logic            r_main_valid, w_main_valid_nxt;
    logic [XLEN-1:0] r_main_inst,  w_main_inst_nxt;
    logic [XLEN-1:0] r_main_pc,    w_main_pc_nxt;
    decode_t         r_main_dec,   w_main_dec_nxt;
    logic            r_skid_valid, w_skid_valid_nxt;
    logic [XLEN-1:0] r_skid_inst,  w_skid_inst_nxt;
    logic [XLEN-1:0] r_skid_pc,    w_skid_pc_nxt;
    decode_t         r_skid_dec,   w_skid_dec_nxt;
    logic            r_ready,      w_ready_nxt;

    logic            w_accept;
    logic            w_main_load;

    decode_lut u_decode_lut (
        .i_inst  (i_inst[24:0]),
        .o_dec_c (w_in_dec)
    );

    assign w_accept    = i_valid && r_ready;
    assign w_main_load = !r_main_valid || i_ready;

    // Next-state for both entries; flush overrides any load or accept.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_inst_nxt  = r_main_inst;
        w_main_pc_nxt    = r_main_pc;
        w_main_dec_nxt   = r_main_dec;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_inst_nxt  = r_skid_inst;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_dec_nxt   = r_skid_dec;
        if (i_flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_inst_nxt  = '0;
            w_main_pc_nxt    = FLUSH_PC_KEEP ? r_main_pc : '0;
            w_main_dec_nxt   = '0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_inst_nxt  = r_skid_inst;
                w_main_pc_nxt    = r_skid_pc;
                w_main_dec_nxt   = r_skid_dec;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_main_valid_nxt = w_accept;
                if (w_accept) begin
                    w_main_inst_nxt = i_inst;
                    w_main_pc_nxt   = i_pc;
                    w_main_dec_nxt  = w_in_dec;
                end
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_inst_nxt  = i_inst;
            w_skid_pc_nxt    = i_pc;
            w_skid_dec_nxt   = w_in_dec;
        end
        w_ready_nxt = !w_skid_valid_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_main_inst  <= '0;
            r_main_pc    <= '0;
            r_main_dec   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
            r_skid_dec   <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_inst  <= w_main_inst_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_main_dec   <= w_main_dec_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_inst  <= w_skid_inst_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_dec   <= w_skid_dec_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_main_valid;
    assign o_inst     = r_main_inst;
    assign o_pc       = r_main_pc;
    assign o_ImmSel   = r_main_dec.imm_sel;
    assign o_rd       = r_main_dec.rd;
    assign o_rs1      = r_main_dec.rs1;
    assign o_rs2      = r_main_dec.rs2;
    assign o_rs1_used = r_main_dec.rs1_used;
    assign o_rs2_used = r_main_dec.rs2_used;
    assign o_rd_we    = r_main_dec.rd_we;
    assign o_illegal  = r_main_dec.illegal;

endmodule
